// File: rtl/ripple_add_sub_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
// Default width and mode encodings.
package ripple_add_sub_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/ripple_add_sub_full_adder.sv
// Single-bit full adder, one link of the ripple chain.
// Purely combinational.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/ripple_add_sub.sv
// Ripple-carry adder/subtractor with a registered result stage.
// One-cycle latency, one operation per cycle.
module ripple_add_sub
    import ripple_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic             is_sub;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             ovf_d;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign is_sub = (sub == SUB);
    assign b_eff  = b ^ {WIDTH{is_sub}};
    assign c[0]   = is_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a_i   (a[i]),
            .b_i   (b_eff[i]),
            .cin_i (c[i]),
            .sum_o (s_d[i]),
            .cout_o(c[i+1])
        );
    end

    assign cout_d = c[WIDTH];
    assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];

    // Result register: load on valid, hold otherwise; valid is a plain delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_add_sub.sv
// Self-checking bench for ripple_add_sub.
// Expected results are queued at drive time and popped on out_valid.
module tb_ripple_add_sub;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         out_valid;

    int   errors;
    int   checks;
    exp_t sb_q[$];
    exp_t held;

    ripple_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model using integer arithmetic, independent of the carry chain.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic isub);
        exp_t e;
        int ua, ub, sa, sb, r, sr;
        ua = int'(ia);
        ub = int'(ib);
        sa = ia[W-1] ? ua - (1 << W) : ua;
        sb = ib[W-1] ? ub - (1 << W) : ub;
        if (isub) begin
            r      = ua - ub;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub;
            sr     = sa + sb;
            e.cout = (r >= (1 << W));
        end
        e.s   = W'(r & ((1 << W) - 1));
        e.ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return e;
    endfunction

    task automatic check_out(input string tag, input logic exp_valid);
        exp_t e;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, ".sb_empty"}, 32'(1), 32'(0));
                e = held;
            end else begin
                e = sb_q.pop_front();
            end
            held = e;
        end else begin
            e = held;
        end
        check({tag, ".s"}, 32'(s), 32'(e.s));
        check({tag, ".cout"}, 32'(cout), 32'(e.cout));
        check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    task automatic drive(input string tag, input logic v, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic isub);
        @(negedge clk);
        in_valid = v;
        a        = ia;
        b        = ib;
        sub      = isub;
        if (v) sb_q.push_back(model(ia, ib, isub));
        @(posedge clk);
        #1;
        check_out(tag, v);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        held     = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;

        #1;
        check("rst.s", 32'(s), 32'(0));
        check("rst.cout", 32'(cout), 32'(0));
        check("rst.ovf", 32'(ovf), 32'(0));
        check("rst.out_valid", 32'(out_valid), 32'(0));

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive("sub15_15", 1'b1, 4'd15, 4'd15, 1'b1);
        check("sub15_15.lit_s", 32'(s), 32'(0));
        check("sub15_15.lit_cout", 32'(cout), 32'(1));
        drive("add15_1", 1'b1, 4'd15, 4'd1, 1'b0);
        check("add15_1.lit_cout", 32'(cout), 32'(1));
        drive("add7_1", 1'b1, 4'd7, 4'd1, 1'b0);
        check("add7_1.lit_s", 32'(s), 32'(8));
        check("add7_1.lit_ovf", 32'(ovf), 32'(1));
        drive("sub8_1", 1'b1, 4'd8, 4'd1, 1'b1);
        check("sub8_1.lit_s", 32'(s), 32'(7));
        check("sub8_1.lit_ovf", 32'(ovf), 32'(1));
        drive("sub3_5", 1'b1, 4'd3, 4'd5, 1'b1);
        check("sub3_5.lit_s", 32'(s), 32'(14));
        check("sub3_5.lit_cout", 32'(cout), 32'(0));

        for (int i = 0; i < 4; i++)
            drive("hold", 1'b0, W'($urandom), W'($urandom), 1'($urandom));

        for (int i = 0; i < 60; i++)
            drive("rand", 1'($urandom_range(0, 3) != 0), W'($urandom),
                  W'($urandom), 1'($urandom));

        drive("b2b0", 1'b1, 4'd9, 4'd6, 1'b0);
        drive("b2b1", 1'b1, 4'd2, 4'd12, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd4;
        sub      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        held = '0;
        check("arst.s", 32'(s), 32'(0));
        check("arst.cout", 32'(cout), 32'(0));
        check("arst.ovf", 32'(ovf), 32'(0));
        check("arst.out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("arst_hold.out_valid", 32'(out_valid), 32'(0));
        check("arst_hold.s", 32'(s), 32'(0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        drive("post_idle", 1'b0, 4'd1, 4'd1, 1'b0);
        drive("post_first", 1'b1, 4'd6, 4'd7, 1'b0);
        drive("post_sub", 1'b1, 4'd0, 4'd1, 1'b1);
        drive("post_tail", 1'b0, 4'd3, 4'd3, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ripple_add_sub.md
Name: ripple_add_sub

Overview:
- Parameterised ripple-carry adder/subtractor for two unsigned/two's-complement operands, selected by a single mode bit.
- Combinational ripple chain of full adders feeding a registered result stage: one-cycle latency from input capture to output.
- Used as the basic arithmetic datapath element in the lab design hierarchy; top-level wrapper is module top.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/mode valid this cycle; captured on rising clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  mode: 0 = add (A+B), 1 = subtract (A-B).
- s  output  WIDTH  registered sum/difference, modulo 2^WIDTH.
- cout  output  1  registered carry out of MSB stage (for subtract: 1 = no borrow, 0 = borrow).
- ovf  output  1  registered signed two's-complement overflow.
- out_valid  output  1  registered copy of in_valid; qualifies s/cout/ovf.

Behaviour:
- Reset: while rst_n = 0 (asserted asynchronously, released synchronously to clk by the system), s = 0, cout = 0, ovf = 0, out_valid = 0, independent of clk.
- Datapath: b_eff[i] = b[i] XOR sub; carry-in to bit 0 = sub; WIDTH full adders in a ripple chain, c[i+1] = majority(a[i], b_eff[i], c[i]), sum[i] = a[i] ^ b_eff[i] ^ c[i].
- cout_next = c[WIDTH]; ovf_next = c[WIDTH] XOR c[WIDTH-1].
- Latency: on a rising clk with in_valid = 1, s/cout/ovf load the combinational result of that cycle's a, b, sub; out_valid <= 1.
- in_valid = 0: s/cout/ovf hold previous values; out_valid <= 0.
- Throughput: one operation per cycle, no backpressure; back-to-back valid inputs produce back-to-back valid outputs.
- Wrap-around: results are modulo 2^WIDTH; e.g. 15+1 -> 0 with cout = 1; 15-15 -> 0 with cout = 1.
- Reset mid-operation: any in-flight result is discarded; outputs go to reset values immediately; first valid result appears one cycle after the first captured in_valid following reset release.
- No X-propagation allowance: unknown inputs while in_valid = 0 must not affect outputs.

Decomposition:
- Shared package: WIDTH default constant, mode encodings ADD = 1'b0, SUB = 1'b1.
- One sub-module: full_adder (a, b, cin -> sum, cout), instantiated WIDTH times via generate loop; result register stage in ripple_add_sub.

Test Plan:
- Subtract equal maxima: a=15, b=15, sub=1, in_valid=1 -> next cycle s=4'b0000, cout=1, ovf=0, out_valid=1.
- Add with wrap: a=15, b=1, sub=0 -> s=4'b0000, cout=1, ovf=0.
- Signed overflow: a=7, b=1, sub=0 -> s=4'b1000, cout=0, ovf=1; a=8, b=1, sub=1 -> s=4'b0111, cout=1, ovf=1.
- Borrow: a=3, b=5, sub=1 -> s=4'b1110, cout=0, ovf=0.
- Hold/valid: after a valid op, drive in_valid=0 with changing a/b -> s/cout/ovf unchanged, out_valid=0.
- Async reset mid-stream: assert rst_n=0 between clk edges during back-to-back ops -> s=0, cout=0, ovf=0, out_valid=0 immediately; after release, first valid op appears one cycle later.
